cache_nway_wb: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate cache; next generation of the team's 2-way line cache.
- Sits between the CPU-side 256-bit line interface (behind the bus adapter) and physical memory.
- Adds configurable associativity, tree pseudo-LRU replacement, an integrated controller FSM, and saturating hit/miss counters.

---
 rtl/cache_nway_wb.sv | 205 ++++++++++++++++++++
 tb/tb_cache_nway_wb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate line cache
// with tree pseudo-LRU replacement and saturating hit/miss counters.
module cache_nway_wb #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_byte_enable256,
    input  logic [255:0] mem_wdata256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int num_sets = 2 ** s_index;
    localparam int s_way    = $clog2(num_ways);

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t r_state;

    logic [255:0]        r_data  [num_sets][num_ways];
    logic [s_tag-1:0]    r_tag   [num_sets][num_ways];
    logic [num_ways-1:0] r_valid [num_sets];
    logic [num_ways-1:0] r_dirty [num_sets];
    logic [num_ways-2:0] r_plru  [num_sets];

    logic [s_way-1:0] r_victim;
    logic             r_refill;
    logic [31:0]      r_hit_cnt;
    logic [31:0]      r_miss_cnt;

    logic [s_index-1:0] w_idx;
    logic [s_tag-1:0]   w_tag;
    logic               w_hit;
    logic [s_way-1:0]   w_hit_way;
    logic [s_way-1:0]   w_victim;
    logic [255:0]       w_merged;
    logic               w_unused;

    // Heap-ordered tree: node n has children 2n+1 (lower) and 2n+2 (upper)
    function automatic logic [s_way-1:0] f_victim(
        input logic [num_ways-2:0] t
    );
        logic [s_way-1:0] v;
        logic             bt;
        int               n;
        v = '0;
        n = 0;
        for (int l = 0; l < s_way; l++) begin
            bt = t[n[s_way-1:0]];
            v  = (v << 1) | s_way'(bt);
            n  = 2 * n + 1 + int'(bt);
        end
        return v;
    endfunction

    function automatic logic [num_ways-2:0] f_touch(
        input logic [num_ways-2:0] t,
        input logic [s_way-1:0]    w
    );
        logic [num_ways-2:0] r;
        logic [s_way-1:0]    ww;
        logic                bt;
        int                  n;
        r  = t;
        ww = w;
        n  = 0;
        for (int l = 0; l < s_way; l++) begin
            bt = ww[s_way-1];
            ww = ww << 1;
            r[n[s_way-1:0]] = ~bt;
            n = 2 * n + 1 + int'(bt);
        end
        return r;
    endfunction

    assign w_idx    = mem_address[s_offset +: s_index];
    assign w_tag    = mem_address[31 -: s_tag];
    assign w_unused = ^mem_address[s_offset-1:0];

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = s_way'(w);
            end
        end
    end

    // An empty way always wins over the PLRU choice
    always_comb begin
        w_victim = f_victim(r_plru[w_idx]);
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_victim = s_way'(w);
        end
    end

    always_comb begin
        w_merged = r_data[w_idx][w_hit_way];
        for (int b = 0; b < 32; b++) begin
            if (mem_byte_enable256[b])
                w_merged[8*b +: 8] = mem_wdata256[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_victim   <= '0;
            r_refill   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            for (int s = 0; s < num_sets; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (mem_read ^ mem_write) r_state <= COMPARE;
                end
                COMPARE: begin
                    if (w_hit) begin
                        if (!r_refill && r_hit_cnt != '1)
                            r_hit_cnt <= r_hit_cnt + 32'd1;
                        r_plru[w_idx] <= f_touch(r_plru[w_idx], w_hit_way);
                        if (mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
                        r_refill <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        if (!r_refill && r_miss_cnt != '1)
                            r_miss_cnt <= r_miss_cnt + 32'd1;
                        r_victim <= w_victim;
                        if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                            r_state <= WRITEBACK;
                        else
                            r_state <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) r_state <= ALLOCATE;
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_plru[w_idx] <= f_touch(r_plru[w_idx], r_victim);
                        r_refill <= 1'b1;
                        r_state  <= COMPARE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == COMPARE && w_hit && mem_write)
            r_data[w_idx][w_hit_way] <= w_merged;
        if (r_state == ALLOCATE && pmem_resp) begin
            r_data[w_idx][r_victim] <= pmem_rdata;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
    end

    assign mem_resp     = (r_state == COMPARE) && w_hit;
    assign mem_rdata256 = mem_resp ? r_data[w_idx][w_hit_way] : '0;
    assign pmem_write   = (r_state == WRITEBACK);
    assign pmem_read    = (r_state == ALLOCATE);
    assign pmem_wdata   = pmem_write ? r_data[w_idx][r_victim] : '0;

    always_comb begin
        pmem_address = '0;
        if (pmem_write)
            pmem_address = {r_tag[w_idx][r_victim], w_idx, {s_offset{1'b0}}};
        else if (pmem_read)
            pmem_address = {w_tag, w_idx, {s_offset{1'b0}}};
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule

// File: tb/tb_cache_nway_wb.sv
// Directed bench for cache_nway_wb with a behavioural cache/memory model.
module tb_cache_nway_wb;

    localparam int WB_LAT   = 3;
    localparam int FILL_LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_byte_enable256 = '0;
    logic [255:0] mem_wdata256 = '0;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    always #5 clk = ~clk;

    cache_nway_wb dut (
        .clk(clk),
        .rst(rst),
        .mem_address(mem_address),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_byte_enable256(mem_byte_enable256),
        .mem_wdata256(mem_wdata256),
        .mem_rdata256(mem_rdata256),
        .mem_resp(mem_resp),
        .pmem_address(pmem_address),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    int checks = 0;
    int errors = 0;

    // model: 8 sets x 4 ways, tree PLRU as root / lower-pair / upper-pair bits
    bit           mv   [8][4];
    bit           md   [8][4];
    logic [23:0]  mt   [8][4];
    logic [255:0] mdat [8][4];
    bit           p_root [8];
    bit           p_lo   [8];
    bit           p_hi   [8];
    int           m_hits;
    int           m_miss;
    logic [255:0] mem [int unsigned];

    bit           e_hit, e_wb;
    logic [31:0]  e_wb_addr, e_fill_addr;
    logic [255:0] e_wb_data, e_rdata;
    int           e_lat;

    bit           o_wb_seen, o_fill_seen;
    logic [31:0]  o_wb_addr, o_fill_addr;
    logic [255:0] o_wb_data, o_rdata;
    int           o_lat;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {8{a}};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                mv[s][w] = 1'b0;
                md[s][w] = 1'b0;
            end
            p_root[s] = 1'b0;
            p_lo[s]   = 1'b0;
            p_hi[s]   = 1'b0;
        end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic touch(input int s, input int w);
        if (w < 2) begin
            p_root[s] = 1'b1;
            p_lo[s]   = (w == 0);
        end else begin
            p_root[s] = 1'b0;
            p_hi[s]   = (w == 2);
        end
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr,
                                input logic [31:0] be,
                                input logic [255:0] wd);
        int s, w;
        logic [23:0] t;
        s = int'(a[7:5]);
        t = a[31:8];
        w = -1;
        e_wb = 1'b0;
        e_wb_addr = '0;
        e_wb_data = '0;
        e_fill_addr = '0;
        for (int i = 0; i < 4; i++)
            if (mv[s][i] && mt[s][i] == t) w = i;
        e_hit = (w >= 0);
        if (e_hit) begin
            m_hits++;
        end else begin
            m_miss++;
            for (int i = 3; i >= 0; i--)
                if (!mv[s][i]) w = i;
            if (w < 0) begin
                if (!p_root[s]) w = p_lo[s] ? 1 : 0;
                else            w = p_hi[s] ? 3 : 2;
            end
            if (mv[s][w] && md[s][w]) begin
                e_wb = 1'b1;
                e_wb_addr = {mt[s][w], a[7:5], 5'b0};
                e_wb_data = mdat[s][w];
            end
            e_fill_addr = {t, a[7:5], 5'b0};
            mdat[s][w] = mem_line(e_fill_addr);
            mt[s][w] = t;
            mv[s][w] = 1'b1;
            md[s][w] = 1'b0;
            touch(s, w);
        end
        if (wr) begin
            for (int b = 0; b < 32; b++)
                if (be[b]) mdat[s][w][8*b +: 8] = wd[8*b +: 8];
            md[s][w] = 1'b1;
        end
        touch(s, w);
        e_rdata = mdat[s][w];
        if (e_hit)     e_lat = 1;
        else if (e_wb) e_lat = 2 + WB_LAT + FILL_LAT;
        else           e_lat = 2 + FILL_LAT;
    endtask

    // Called just after a negedge with the DUT idle; returns after a negedge
    task automatic do_req(input logic [31:0] a, input bit wr,
                          input logic [31:0] be, input logic [255:0] wd);
        int  cyc, wbc, flc;
        bit  done;
        model_access(a, wr, be, wd);
        o_wb_seen = 0; o_fill_seen = 0; o_lat = 0;
        o_wb_addr = '0; o_fill_addr = '0; o_wb_data = '0; o_rdata = '0;
        mem_address = a;
        mem_read = !wr;
        mem_write = wr;
        mem_byte_enable256 = be;
        mem_wdata256 = wd;
        cyc = 0; wbc = 0; flc = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pmem_resp) pmem_resp = 1'b0;
            if (pmem_write) begin
                if (wbc == 0) begin
                    o_wb_seen = 1; o_wb_addr = pmem_address;
                    o_wb_data = pmem_wdata;
                    chk32("wb_expected", 32'(e_wb), 32'd1);
                    chk32("wb_addr", pmem_address, e_wb_addr);
                    chk("wb_data", pmem_wdata, e_wb_data);
                end
                wbc++;
                if (wbc == WB_LAT) begin
                    mem[e_wb_addr] = e_wb_data;
                    pmem_resp = 1'b1;
                end
            end
            if (pmem_read) begin
                if (flc == 0) begin
                    o_fill_seen = 1; o_fill_addr = pmem_address;
                    chk32("fill_expected", 32'(e_hit), 32'd0);
                    chk32("fill_addr", pmem_address, e_fill_addr);
                    chk32("fill_after_wb", 32'(wbc), e_wb ? WB_LAT : 0);
                end
                flc++;
                if (flc == FILL_LAT) begin
                    pmem_rdata = mem_line(e_fill_addr);
                    pmem_resp = 1'b1;
                end
            end
            if (mem_resp) begin
                done = 1;
                o_lat = cyc;
                o_rdata = mem_rdata256;
                chk32("latency", cyc, e_lat);
                if (!wr) chk("rdata", mem_rdata256, e_rdata);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL req_timeout: addr %h no mem_resp in %0d cycles",
                     a, cyc);
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk32("hit_count", hit_count, m_hits);
        chk32("miss_count", miss_count, m_miss);
        chk32("idle_resp", 32'(mem_resp), 32'd0);
    endtask

    initial begin
        logic [255:0] a5_line, bf_line;
        int cyc;
        bit seen;
        a5_line = {32{8'hA5}};
        bf_line = {{28{8'hA5}}, 32'hDEADBEEF};
        mem[32'h0000_1000] = a5_line;
        model_reset();

        #12;
        chk32("rst_resp", 32'(mem_resp), 32'd0);
        chk32("rst_pread", 32'(pmem_read), 32'd0);
        chk32("rst_pwrite", 32'(pmem_write), 32'd0);
        chk32("rst_paddr", pmem_address, 32'd0);
        chk32("rst_hits", hit_count, 32'd0);
        chk32("rst_miss", miss_count, 32'd0);
        chk("rst_rdata", mem_rdata256, 256'd0);
        chk("rst_wdata", pmem_wdata, 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_req(32'h0000_1000, 0, '0, '0);
        chk32("first_fill_addr", o_fill_addr, 32'h0000_1000);
        chk32("first_no_wb", 32'(o_wb_seen), 32'd0);
        chk("first_rdata", o_rdata, a5_line);
        chk32("first_miss", miss_count, 32'd1);
        chk32("first_hit", hit_count, 32'd0);

        do_req(32'h0000_1000, 0, '0, '0);
        chk32("rehit_lat", o_lat, 32'd1);
        chk32("rehit_nofill", 32'(o_fill_seen), 32'd0);
        chk32("rehit_hits", hit_count, 32'd1);

        do_req(32'h0000_1000, 1, 32'h0000_000F,
               {{7{32'hCAFEF00D}}, 32'hDEADBEEF});
        do_req(32'h0000_1000, 0, '0, '0);
        chk("merge_rdata", o_rdata, bf_line);

        do_req(32'h0000_2000, 0, '0, '0);
        do_req(32'h0000_3000, 0, '0, '0);
        do_req(32'h0000_4000, 0, '0, '0);
        do_req(32'h0000_5000, 0, '0, '0);
        chk32("evict_wb_seen", 32'(o_wb_seen), 32'd1);
        chk32("evict_wb_addr", o_wb_addr, 32'h0000_1000);
        chk("evict_wb_data", o_wb_data, bf_line);
        chk32("evict_fill", o_fill_addr, 32'h0000_5000);

        do_req(32'h0000_1000, 0, '0, '0);
        chk("refetch_rdata", o_rdata, bf_line);

        do_req(32'h0000_6020, 1, 32'hFFFF_0000, {8{32'h1234_5678}});
        do_req(32'h0000_7020, 0, '0, '0);
        do_req(32'h0000_8020, 0, '0, '0);
        do_req(32'h0000_9020, 0, '0, '0);

        // dirty eviction interrupted by reset
        model_access(32'h0000_A020, 0, '0, '0);
        chk32("abort_model_wb", e_wb_addr, 32'h0000_6020);
        mem_address = 32'h0000_A020;
        mem_read = 1'b1;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = pmem_write;
        end
        chk32("abort_wb_seen", 32'(seen), 32'd1);
        chk32("abort_wb_addr", pmem_address, 32'h0000_6020);
        #1;
        rst = 1'b0;
        #1;
        chk32("abort_pwrite", 32'(pmem_write), 32'd0);
        chk32("abort_pread", 32'(pmem_read), 32'd0);
        chk32("abort_resp", 32'(mem_resp), 32'd0);
        mem_read = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk32("abort_hits", hit_count, 32'd0);
        chk32("abort_miss", miss_count, 32'd0);

        do_req(32'h0000_2000, 0, '0, '0);
        chk32("post_rst_no_wb", 32'(o_wb_seen), 32'd0);
        chk32("post_rst_fill", o_fill_addr, 32'h0000_2000);
        chk32("post_rst_miss", miss_count, 32'd1);

        mem_address = 32'h0000_2000;
        mem_read = 1'b1;
        mem_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk32("both_resp", 32'(mem_resp), 32'd0);
            chk32("both_pread", 32'(pmem_read), 32'd0);
            chk32("both_pwrite", 32'(pmem_write), 32'd0);
        end
        chk32("both_hits", hit_count, m_hits);
        chk32("both_miss", miss_count, m_miss);
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
